dram_arbiter: RTL and testbench

Shares the single DRAM controller between the 68030 CPU bus and a secondary DMA master (disk/video engine). It sits between the CPU bus decode and the DRAM controller. It muxes one requester's cycle onto the controller's nCS/nAS/RnW/SIZ/ADDR inputs and routes the controller's DSACK termination back to the winner. Priority is fixed to the CPU, with a DMA starvation override and a DMA burst limit.

---
 rtl/dram_arbiter_pkg.sv | 24 ++
 rtl/dram_arb_prio.sv | 33 +++
 rtl/dram_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the DRAM arbiter between the 68030 bus and the DMA master.
package dram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_CYC = 3'd1,
    ST_CPU_END = 3'd2,
    ST_DMA_CYC = 3'd3,
    ST_DMA_END = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_CPU  = 2'd1,
    WIN_DMA  = 2'd2
  } winner_t;

  // Values presented to the DRAM controller when nobody owns it
  localparam logic       DC_IDLE_NCS = 1'b1;
  localparam logic       DC_IDLE_NAS = 1'b1;
  localparam logic       DC_IDLE_RNW = 1'b1;
  localparam logic [1:0] DC_IDLE_SIZ = 2'b00;

endpackage

// File: rtl/dram_arb_prio.sv
// Combinational winner select: fixed CPU priority, DMA starvation override, DMA burst limit.
module dram_arb_prio
  import dram_arbiter_pkg::*;
#(
  parameter int DMA_MAX_WAIT  = 8,
  parameter int DMA_BURST_MAX = 4,
  parameter int CNT_W         = 4
) (
  input  logic             cpu_rq,
  input  logic             dma_req,
  input  logic [CNT_W-1:0] wait_cnt,
  input  logic [CNT_W-1:0] burst_cnt,
  output winner_t          winner
);

  localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(DMA_MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(DMA_BURST_MAX);

  // Burst limit beats starvation; starvation beats plain CPU priority
  always_comb begin
    winner = WIN_NONE;
    if (cpu_rq && (burst_cnt >= BURST_LIM)) begin
      winner = WIN_CPU;
    end else if (dma_req && (wait_cnt >= WAIT_LIM)) begin
      winner = WIN_DMA;
    end else if (cpu_rq) begin
      winner = WIN_CPU;
    end else if (dma_req) begin
      winner = WIN_DMA;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Shares the DRAM controller between the 68030 CPU bus and a DMA master.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 28,
  parameter int DMA_MAX_WAIT  = 8,
  parameter int DMA_BURST_MAX = 4,
  parameter int CNT_W         = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              cpu_nCS,
  input  logic              cpu_nAS,
  input  logic              cpu_RnW,
  input  logic [1:0]        cpu_SIZ,
  input  logic [ADDR_W-1:0] cpu_ADDR,
  output logic              cpu_DSACK0,
  output logic              cpu_DSACK1,
  input  logic              dma_req,
  input  logic              dma_RnW,
  input  logic [1:0]        dma_SIZ,
  input  logic [ADDR_W-1:0] dma_ADDR,
  output logic              dma_grant,
  output logic              dma_ack,
  output logic              dc_nCS,
  output logic              dc_nAS,
  output logic              dc_RnW,
  output logic [1:0]        dc_SIZ,
  output logic [ADDR_W-1:0] dc_ADDR,
  input  logic              dc_DSACK0,
  input  logic              dc_DSACK1
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] burst_cnt;
  logic             dma_ack_nxt;
  logic             cpu_rq;
  logic             dma_owns;
  logic             dsack_both;
  logic             dsack_clear;
  winner_t          winner;

  assign cpu_rq      = ~cpu_nCS & ~cpu_nAS;
  assign dma_owns    = (state == ST_DMA_CYC) || (state == ST_DMA_END);
  assign dsack_both  = dc_DSACK0 & dc_DSACK1;
  assign dsack_clear = ~dc_DSACK0 & ~dc_DSACK1;

  dram_arb_prio #(
    .DMA_MAX_WAIT (DMA_MAX_WAIT),
    .DMA_BURST_MAX(DMA_BURST_MAX),
    .CNT_W        (CNT_W)
  ) u_prio (
    .cpu_rq   (cpu_rq),
    .dma_req  (dma_req),
    .wait_cnt (wait_cnt),
    .burst_cnt(burst_cnt),
    .winner   (winner)
  );

  // State and ack registers; reset abandons any cycle in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= ST_IDLE;
      dma_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      dma_ack <= dma_ack_nxt;
    end
  end

  // Next-state: grant from IDLE, release once the controller drops DSACK
  always_comb begin
    state_nxt   = state;
    dma_ack_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (winner == WIN_CPU) begin
          state_nxt = ST_CPU_CYC;
        end else if (winner == WIN_DMA) begin
          state_nxt = ST_DMA_CYC;
        end
      end
      ST_CPU_CYC: begin
        if (cpu_nAS) begin
          state_nxt = ST_CPU_END;
        end
      end
      ST_CPU_END: begin
        if (dsack_clear) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DMA_CYC: begin
        if (dsack_both) begin
          state_nxt   = ST_DMA_END;
          dma_ack_nxt = 1'b1;
        end
      end
      ST_DMA_END: begin
        if (dsack_clear) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // DMA wait counter: counts while DMA is kept waiting, cleared on DMA grant
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= '0;
    end else if ((state == ST_IDLE) && (state_nxt == ST_DMA_CYC)) begin
      wait_cnt <= '0;
    end else if (dma_req && !dma_owns && (wait_cnt != '1)) begin
      wait_cnt <= wait_cnt + CNT_ONE;
    end
  end

  // DMA burst counter: counts completed DMA cycles, cleared by any CPU cycle
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      burst_cnt <= '0;
    end else if (state == ST_CPU_CYC) begin
      burst_cnt <= '0;
    end else if ((state == ST_DMA_CYC) && dsack_both && (burst_cnt != '1)) begin
      burst_cnt <= burst_cnt + CNT_ONE;
    end
  end

  // Output mux decoded from the registered owner
  always_comb begin
    dc_nCS     = DC_IDLE_NCS;
    dc_nAS     = DC_IDLE_NAS;
    dc_RnW     = DC_IDLE_RNW;
    dc_SIZ     = DC_IDLE_SIZ;
    dc_ADDR    = '0;
    cpu_DSACK0 = 1'b0;
    cpu_DSACK1 = 1'b0;
    dma_grant  = 1'b0;
    case (state)
      ST_CPU_CYC: begin
        dc_nCS     = cpu_nCS;
        dc_nAS     = cpu_nAS;
        dc_RnW     = cpu_RnW;
        dc_SIZ     = cpu_SIZ;
        dc_ADDR    = cpu_ADDR;
        cpu_DSACK0 = dc_DSACK0;
        cpu_DSACK1 = dc_DSACK1;
      end
      ST_CPU_END: begin
        // Keep the controller selected through precharge; strobe is already released
        dc_nCS  = 1'b0;
        dc_RnW  = cpu_RnW;
        dc_SIZ  = cpu_SIZ;
        dc_ADDR = cpu_ADDR;
      end
      ST_DMA_CYC: begin
        dc_nCS    = 1'b0;
        dc_nAS    = 1'b0;
        dc_RnW    = dma_RnW;
        dc_SIZ    = dma_SIZ;
        dc_ADDR   = dma_ADDR;
        dma_grant = 1'b1;
      end
      ST_DMA_END: begin
        dc_nCS    = 1'b0;
        dc_RnW    = dma_RnW;
        dc_SIZ    = dma_SIZ;
        dc_ADDR   = dma_ADDR;
        dma_grant = 1'b1;
      end
      default: begin
        dc_nCS = DC_IDLE_NCS;
      end
    endcase
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_dram_arbiter;

  localparam int ADDR_W  = 28;
  localparam int MAXW    = 8;
  localparam int BMAX    = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_SAT = 15;

  logic              CLK;
  logic              nRST;
  logic              cpu_nCS, cpu_nAS, cpu_RnW;
  logic [1:0]        cpu_SIZ;
  logic [ADDR_W-1:0] cpu_ADDR;
  logic              cpu_DSACK0, cpu_DSACK1;
  logic              dma_req, dma_RnW;
  logic [1:0]        dma_SIZ;
  logic [ADDR_W-1:0] dma_ADDR;
  logic              dma_grant, dma_ack;
  logic              dc_nCS, dc_nAS, dc_RnW;
  logic [1:0]        dc_SIZ;
  logic [ADDR_W-1:0] dc_ADDR;
  logic              dc_DSACK0, dc_DSACK1;

  dram_arbiter #(
    .ADDR_W       (ADDR_W),
    .DMA_MAX_WAIT (MAXW),
    .DMA_BURST_MAX(BMAX),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cpu_nCS   (cpu_nCS),
    .cpu_nAS   (cpu_nAS),
    .cpu_RnW   (cpu_RnW),
    .cpu_SIZ   (cpu_SIZ),
    .cpu_ADDR  (cpu_ADDR),
    .cpu_DSACK0(cpu_DSACK0),
    .cpu_DSACK1(cpu_DSACK1),
    .dma_req   (dma_req),
    .dma_RnW   (dma_RnW),
    .dma_SIZ   (dma_SIZ),
    .dma_ADDR  (dma_ADDR),
    .dma_grant (dma_grant),
    .dma_ack   (dma_ack),
    .dc_nCS    (dc_nCS),
    .dc_nAS    (dc_nAS),
    .dc_RnW    (dc_RnW),
    .dc_SIZ    (dc_SIZ),
    .dc_ADDR   (dc_ADDR),
    .dc_DSACK0 (dc_DSACK0),
    .dc_DSACK1 (dc_DSACK1)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the controller, whether it is in its release phase
  int owner;   // 0 = nobody, 1 = CPU, 2 = DMA
  bit ending;
  int waitc;
  int burstc;
  bit ack_exp;
  int dma_left;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = 0; ending = 0; waitc = 0; burstc = 0; ack_exp = 0;
  endtask

  task automatic idle_inputs();
    cpu_nCS = 1; cpu_nAS = 1; cpu_RnW = 1; cpu_SIZ = 2'b00; cpu_ADDR = '0;
    dma_req = 0; dma_RnW = 1; dma_SIZ = 2'b00; dma_ADDR = '0;
    dc_DSACK0 = 0; dc_DSACK1 = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_grant", 64'(dma_grant), 64'(0));
    chk("rst_ack", 64'(dma_ack), 64'(0));
    chk("rst_cpu_dsack", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(0));
    chk("rst_dc", 64'({dc_nCS, dc_nAS, dc_RnW, dc_SIZ, dc_ADDR}),
        64'({1'b1, 1'b1, 1'b1, 2'b00, {ADDR_W{1'b0}}}));
  endtask

  task automatic check_outputs();
    chk("dma_ack", 64'(dma_ack), 64'(ack_exp));
    chk("dma_grant", 64'(dma_grant), 64'(owner == 2));
    if (owner == 0) begin
      chk("dc_idle", 64'({dc_nCS, dc_nAS, dc_RnW, dc_SIZ, dc_ADDR}),
          64'({1'b1, 1'b1, 1'b1, 2'b00, {ADDR_W{1'b0}}}));
      chk("cpu_dsack_idle", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(0));
    end else if (owner == 1 && !ending) begin
      chk("dc_cpu", 64'({dc_nCS, dc_nAS, dc_RnW, dc_SIZ, dc_ADDR}),
          64'({cpu_nCS, cpu_nAS, cpu_RnW, cpu_SIZ, cpu_ADDR}));
      chk("cpu_dsack", 64'({cpu_DSACK1, cpu_DSACK0}), 64'({dc_DSACK1, dc_DSACK0}));
    end else if (owner == 1) begin
      chk("cpu_end_nas", 64'(dc_nAS), 64'(1));
      chk("cpu_end_dsack", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(0));
    end else begin
      chk("dc_dma", 64'({dc_nCS, dc_nAS, dc_RnW, dc_SIZ, dc_ADDR}),
          64'({1'b0, ending, dma_RnW, dma_SIZ, dma_ADDR}));
      chk("dma_cpu_dsack", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(0));
    end
  endtask

  // Advance the model by one clock using the inputs the DUT just sampled
  task automatic model_step();
    bit cpu_rq, both, none, pick_cpu, pick_dma;
    int n_owner, n_wait, n_burst;
    bit n_end, n_ack;
    cpu_rq  = !cpu_nCS && !cpu_nAS;
    both    = dc_DSACK0 && dc_DSACK1;
    none    = !dc_DSACK0 && !dc_DSACK1;
    n_owner = owner; n_end = ending; n_burst = burstc; n_ack = 0;
    n_wait  = (dma_req && owner != 2) ? ((waitc < CNT_SAT) ? waitc + 1 : CNT_SAT) : waitc;
    if (owner == 0) begin
      pick_cpu = 0; pick_dma = 0;
      if (cpu_rq && burstc >= BMAX) pick_cpu = 1;
      else if (dma_req && waitc >= MAXW) pick_dma = 1;
      else if (cpu_rq) pick_cpu = 1;
      else if (dma_req) pick_dma = 1;
      if (pick_cpu) begin n_owner = 1; n_end = 0; end
      if (pick_dma) begin n_owner = 2; n_end = 0; n_wait = 0; end
    end else if (owner == 1) begin
      if (!ending) begin
        n_burst = 0;
        if (cpu_nAS) n_end = 1;
      end else if (none) begin
        n_owner = 0; n_end = 0;
      end
    end else begin
      if (!ending) begin
        if (both) begin
          n_ack = 1; n_end = 1;
          n_burst = (burstc < CNT_SAT) ? burstc + 1 : CNT_SAT;
        end
      end else if (none) begin
        n_owner = 0; n_end = 0;
      end
    end
    owner = n_owner; ending = n_end; waitc = n_wait; burstc = n_burst; ack_exp = n_ack;
  endtask

  task automatic cycle();
    @(negedge CLK);
    check_outputs();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  // Well-behaved bus masters and a DRAM controller that terminates immediately
  task automatic respond(input bit cpu_on);
    bit strobe;
    strobe    = !dc_nCS && !dc_nAS;
    dc_DSACK0 = strobe;
    dc_DSACK1 = strobe;
    cpu_nCS   = !cpu_on;
    if (!cpu_nAS && cpu_DSACK0 && cpu_DSACK1) cpu_nAS = 1;
    else cpu_nAS = !cpu_on;
    if (dma_ack && dma_left > 0) dma_left--;
    dma_req = !dma_ack && (dma_left > 0);
  endtask

  initial begin
    bit got;
    bit prev_grant;
    int run, max_run;

    nRST = 0;
    idle_inputs();
    model_reset();
    dma_left = 0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs();
    nRST = 1;
    cycle();

    // CPU long read at 0x100
    cpu_nCS = 0; cpu_nAS = 0; cpu_RnW = 1; cpu_SIZ = 2'b00; cpu_ADDR = 28'h0000100;
    cycle();
    chk("cpu_rd_nas", 64'(dc_nAS), 64'(0));
    chk("cpu_rd_addr", 64'(dc_ADDR), 64'(28'h0000100));
    dc_DSACK0 = 1; dc_DSACK1 = 1;
    cycle();
    chk("cpu_rd_dsack", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(2'b11));
    cpu_nAS = 1;
    cycle();
    cycle();
    chk("cpu_rd_hold", 64'(dc_nCS), 64'(0));
    dc_DSACK0 = 0; dc_DSACK1 = 0; cpu_nCS = 1;
    cycle();
    chk("cpu_rd_release", 64'(dc_nCS), 64'(1));

    // DMA byte write at 0xABCDE0
    dma_req = 1; dma_RnW = 0; dma_SIZ = 2'b01; dma_ADDR = 28'h0ABCDE0;
    cycle();
    chk("dma_wr_grant", 64'(dma_grant), 64'(1));
    chk("dma_wr_rnw", 64'(dc_RnW), 64'(0));
    cycle();
    dc_DSACK0 = 1; dc_DSACK1 = 1;
    cycle();
    chk("dma_wr_ack", 64'(dma_ack), 64'(1));
    chk("dma_wr_nas_rel", 64'(dc_nAS), 64'(1));
    dma_req = 0;
    cycle();
    chk("dma_wr_ack_once", 64'(dma_ack), 64'(0));
    chk("dma_wr_hold", 64'(dma_grant), 64'(1));
    dc_DSACK0 = 0; dc_DSACK1 = 0;
    cycle();
    chk("dma_wr_release", 64'(dma_grant), 64'(0));
    cycle();

    // Simultaneous request with wait_cnt = 0: CPU wins
    cpu_nCS = 0; cpu_nAS = 0; cpu_ADDR = 28'h0000200; dma_req = 1;
    cycle();
    chk("simul_cpu_wins", 64'(dma_grant), 64'(0));
    chk("simul_cpu_nas", 64'(dc_nAS), 64'(0));
    dc_DSACK0 = 1; dc_DSACK1 = 0;
    cycle();
    chk("simul_dsack_follow", 64'({cpu_DSACK1, cpu_DSACK0}), 64'(2'b01));

    // Back-to-back CPU with DMA held: starvation override must grant DMA
    dma_left = 1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      respond(1'b1);
      cycle();
      if (dma_grant) got = 1;
    end
    chk("starve_grant", 64'(got), 64'(1));
    for (int i = 0; i < 50 && dma_left > 0; i++) begin
      respond(1'b1);
      cycle();
    end

    // DMA stream of 6 while the CPU keeps requesting
    dma_left = 6;
    run = 0; max_run = 0; prev_grant = dma_grant;
    for (int i = 0; i < 600 && dma_left > 0; i++) begin
      respond(1'b1);
      cycle();
      if (dma_grant && !prev_grant) begin
        run++;
        if (run > max_run) max_run = run;
      end
      if (!dma_grant && !dc_nCS) run = 0;
      prev_grant = dma_grant;
    end
    chk("stream_done", 64'(dma_left), 64'(0));
    chk("burst_limit", 64'(max_run <= BMAX), 64'(1));
    for (int i = 0; i < 20; i++) begin
      respond(1'b0);
      cycle();
    end

    // Reset in the middle of a DMA cycle
    idle_inputs();
    dma_left = 0;
    cycle();
    dma_req = 1; dma_ADDR = 28'h0123450;
    cycle();
    cycle();
    chk("pre_rst_grant", 64'(dma_grant), 64'(1));
    #5 nRST = 0;
    #1;
    check_reset_outputs();
    model_reset();
    cpu_nCS = 0; cpu_nAS = 0;
    @(posedge CLK);
    #1;
    nRST = 1;
    cycle();
    chk("post_rst_cpu_wins", 64'(dma_grant), 64'(0));
    chk("post_rst_cpu_nas", 64'(dc_nAS), 64'(0));
    dma_left = 1;
    for (int i = 0; i < 40; i++) begin
      respond(1'b0);
      cycle();
    end

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cpu_nCS   = ($urandom_range(3) == 0);
      cpu_nAS   = 1'($urandom_range(1));
      cpu_RnW   = 1'($urandom_range(1));
      cpu_SIZ   = 2'($urandom_range(3));
      cpu_ADDR  = ADDR_W'($urandom());
      dma_req   = ($urandom_range(9) < 6);
      dma_RnW   = 1'($urandom_range(1));
      dma_SIZ   = 2'($urandom_range(3));
      dma_ADDR  = ADDR_W'($urandom());
      dc_DSACK0 = 1'($urandom_range(1));
      dc_DSACK1 = 1'($urandom_range(1));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
